// File: rtl/tdm_pkg.sv
// Shared constants, state encoding and lane-offset helper for the TDM demultiplexer.
package tdm_pkg;

  localparam int NUM_SLOTS = 8;
  localparam int SLOT_W    = 3;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Bit offset of channel k inside the packed frame word.
  function automatic int chan_lsb(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/tdm_demux8_if.sv
// Stream-in / frame-out bundle of the TDM demultiplexer.
// Handshake: din/frame_sync are consumed on every rising edge where din_valid=1 (no back-pressure);
// frame_valid and sync_err are single-cycle pulses with no acknowledge.
interface tdm_demux8_if #(
  parameter int WIDTH = 1
);
  import tdm_pkg::*;

  logic [WIDTH-1:0]           din;
  logic                       din_valid;
  logic                       frame_sync;
  logic [NUM_SLOTS*WIDTH-1:0] frame_data;
  logic                       frame_valid;
  logic                       locked;
  logic                       sync_err;
  logic [SLOT_W-1:0]          slot;
  state_t                     state;

  modport master (
    output din, din_valid, frame_sync,
    input  frame_data, frame_valid, locked, sync_err, slot, state
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output frame_data, frame_valid, locked, sync_err, slot, state
  );

endinterface

// File: rtl/tdm_slot_tracker.sv
// Frame-alignment tracker: hunt/lock state machine, slot counter and flywheel miss counter.
module tdm_slot_tracker
  import tdm_pkg::*;
#(
  parameter int MISS_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [SLOT_W-1:0] slot,
  output logic              locked,
  output logic              accept,
  output logic              commit,
  output logic [SLOT_W-1:0] wr_idx,
  output logic              sync_err,
  output state_t            state
);

  localparam int MISS_W = $clog2(MISS_MAX + 1);

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [MISS_W-1:0] miss_q, miss_d, miss_inc;
  logic              sync_err_q, sync_err_d;

  assign miss_inc = miss_q + MISS_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      slot_q     <= '0;
      miss_q     <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      miss_q     <= miss_d;
      sync_err_q <= sync_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    miss_d     = miss_q;
    accept     = 1'b0;
    commit     = 1'b0;
    sync_err_d = 1'b0;
    wr_idx     = slot_q;
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (frame_sync) begin
            accept  = 1'b1;
            wr_idx  = '0;
            slot_d  = SLOT_W'(1);
            miss_d  = '0;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (slot_q != '0) begin
            accept = 1'b1;
            if (frame_sync) begin
              // Marker arrived mid-frame: restart the frame on this sample.
              wr_idx     = '0;
              slot_d     = SLOT_W'(1);
              miss_d     = '0;
              sync_err_d = 1'b1;
            end else begin
              slot_d = slot_q + SLOT_W'(1);
              commit = (slot_q == SLOT_W'(NUM_SLOTS - 1));
            end
          end else if (frame_sync) begin
            accept = 1'b1;
            slot_d = SLOT_W'(1);
            miss_d = '0;
          end else if (miss_inc == MISS_W'(MISS_MAX)) begin
            state_d = HUNT;
            slot_d  = '0;
            miss_d  = '0;
          end else begin
            // Flywheel: trust the counter and take this sample as slot 0.
            accept = 1'b1;
            slot_d = SLOT_W'(1);
            miss_d = miss_inc;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign slot     = slot_q;
  assign locked   = (state_q == LOCKED);
  assign sync_err = sync_err_q;
  assign state    = state_q;

endmodule

// File: rtl/tdm_demux8.sv
// Eight-channel TDM demultiplexer: shadows slots 0..6 and commits a whole frame on slot 7.
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int MISS_MAX = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  tdm_demux8_if.slave   bus
);

  logic                       accept;
  logic                       commit;
  logic [SLOT_W-1:0]          wr_idx;
  logic [WIDTH-1:0]           shadow_q [NUM_SLOTS-1];
  logic [NUM_SLOTS*WIDTH-1:0] frame_q;
  logic                       frame_valid_q;

  tdm_slot_tracker #(
    .MISS_MAX (MISS_MAX)
  ) u_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (bus.din_valid),
    .frame_sync (bus.frame_sync),
    .slot       (bus.slot),
    .locked     (bus.locked),
    .accept     (accept),
    .commit     (commit),
    .wr_idx     (wr_idx),
    .sync_err   (bus.sync_err),
    .state      (bus.state)
  );

  // Slot 7 never lands in the shadow; it goes straight into the committed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_SLOTS - 1; k++) shadow_q[k] <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      frame_valid_q <= commit;
      if (accept && !commit) shadow_q[wr_idx] <= bus.din;
      if (commit) begin
        for (int k = 0; k < NUM_SLOTS - 1; k++)
          frame_q[chan_lsb(k, WIDTH) +: WIDTH] <= shadow_q[k];
        frame_q[chan_lsb(NUM_SLOTS - 1, WIDTH) +: WIDTH] <= bus.din;
      end
    end
  end

  assign bus.frame_data  = frame_q;
  assign bus.frame_valid = frame_valid_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed bench for tdm_demux8 with WIDTH=8, MISS_MAX=3.
module tb_tdm_demux8;
  import tdm_pkg::*;

  localparam int WIDTH    = 8;
  localparam int MISS_MAX = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  tdm_demux8_if #(.WIDTH(WIDTH)) bus ();

  tdm_demux8 #(
    .WIDTH    (WIDTH),
    .MISS_MAX (MISS_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Expected frame word for a frame whose slot k carried base+k.
  function automatic logic [63:0] exp_frame(input logic [7:0] base);
    logic [63:0] f;
    f = '0;
    for (int k = 0; k < 8; k++) f[k*8 +: 8] = 8'(base + 8'(k));
    return f;
  endfunction

  task automatic send(input logic [7:0] d, input logic s);
    bus.din        = d;
    bus.din_valid  = 1'b1;
    bus.frame_sync = s;
    @(posedge clk);
    #1;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    bus.din        = '0;
  endtask

  task automatic send_frame(input logic [7:0] base, input logic s, output int pulses);
    pulses = 0;
    send(base, s);
    if (bus.frame_valid) pulses++;
    for (int i = 1; i < 7; i++) begin
      send(8'(base + 8'(i)), 1'b0);
      if (bus.frame_valid) pulses++;
    end
    send(8'(base + 8'd7), 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.frame_data !== 64'h0) begin bad++; $display("FAIL reset_frame_data got=%h exp=0", bus.frame_data); end
    total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL reset_frame_valid got=%b exp=0", bus.frame_valid); end
    total++; if (bus.sync_err !== 1'b0) begin bad++; $display("FAIL reset_sync_err got=%b exp=0", bus.sync_err); end
    total++; if (bus.locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b exp=0", bus.locked); end
    total++; if (bus.slot !== 3'd0) begin bad++; $display("FAIL reset_slot got=%0d exp=0", bus.slot); end
    total++; if (bus.state !== HUNT) begin bad++; $display("FAIL reset_state got=%0d exp=HUNT", bus.state); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_aligned;
    int pulses;
    pulses = 0;
    send(8'h10, 1'b1);
    total++; if (bus.slot !== 3'd1) begin bad++; $display("FAIL aligned_slot1 got=%0d exp=1", bus.slot); end
    total++; if (bus.locked !== 1'b1) begin bad++; $display("FAIL aligned_locked got=%b exp=1", bus.locked); end
    for (int i = 1; i < 7; i++) begin
      send(8'(8'h10 + 8'(i)), 1'b0);
      if (bus.frame_valid) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL aligned_early_valid got=%0d exp=0", pulses); end
    send(8'h17, 1'b0);
    total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL aligned_valid got=%b exp=1", bus.frame_valid); end
    total++; if (bus.frame_data !== 64'h1716151413121110) begin bad++; $display("FAIL aligned_data got=%h exp=1716151413121110", bus.frame_data); end
    total++; if (bus.slot !== 3'd0) begin bad++; $display("FAIL aligned_slot_wrap got=%0d exp=0", bus.slot); end
    @(posedge clk);
    #1;
    total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL aligned_pulse_width got=%b exp=0", bus.frame_valid); end
  endtask

  task automatic test_gapped;
    int pulses;
    pulses = 0;
    send(8'h10, 1'b1);
    for (int i = 1; i < 4; i++) send(8'(8'h10 + 8'(i)), 1'b0);
    total++; if (bus.slot !== 3'd4) begin bad++; $display("FAIL gap_slot_before got=%0d exp=4", bus.slot); end
    bus.frame_sync = 1'b1;
    @(posedge clk);
    #1;
    bus.frame_sync = 1'b0;
    total++; if (bus.sync_err !== 1'b0) begin bad++; $display("FAIL gap_sync_ignored got=%b exp=0", bus.sync_err); end
    repeat (2) begin @(posedge clk); #1; end
    total++; if (bus.slot !== 3'd4) begin bad++; $display("FAIL gap_slot_hold got=%0d exp=4", bus.slot); end
    for (int i = 4; i < 7; i++) begin
      send(8'(8'h10 + 8'(i)), 1'b0);
      if (bus.frame_valid) pulses++;
    end
    send(8'h17, 1'b0);
    total++; if (bus.frame_valid !== 1'b1 || pulses != 0) begin bad++; $display("FAIL gap_valid got=%b early=%0d exp=1 early=0", bus.frame_valid, pulses); end
    total++; if (bus.frame_data !== 64'h1716151413121110) begin bad++; $display("FAIL gap_data got=%h exp=1716151413121110", bus.frame_data); end
  endtask

  task automatic test_misalign;
    send(8'h20, 1'b1);
    for (int i = 1; i < 5; i++) send(8'(8'h20 + 8'(i)), 1'b0);
    total++; if (bus.slot !== 3'd5) begin bad++; $display("FAIL mis_slot_before got=%0d exp=5", bus.slot); end
    send(8'hAA, 1'b1);
    total++; if (bus.sync_err !== 1'b1) begin bad++; $display("FAIL mis_sync_err got=%b exp=1", bus.sync_err); end
    total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL mis_no_commit got=%b exp=0", bus.frame_valid); end
    total++; if (bus.slot !== 3'd1) begin bad++; $display("FAIL mis_slot got=%0d exp=1", bus.slot); end
    total++; if (bus.frame_data !== 64'h1716151413121110) begin bad++; $display("FAIL mis_data_hold got=%h exp=1716151413121110", bus.frame_data); end
    send(8'hA1, 1'b0);
    total++; if (bus.sync_err !== 1'b0) begin bad++; $display("FAIL mis_pulse_width got=%b exp=0", bus.sync_err); end
    for (int i = 2; i < 8; i++) send(8'(8'hA0 + 8'(i)), 1'b0);
    total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL mis_recommit_valid got=%b exp=1", bus.frame_valid); end
    total++; if (bus.frame_data !== 64'hA7A6A5A4A3A2A1AA) begin bad++; $display("FAIL mis_recommit_data got=%h exp=A7A6A5A4A3A2A1AA", bus.frame_data); end
  endtask

  task automatic test_flywheel;
    int pulses;
    send_frame(8'h30, 1'b1, pulses);
    total++; if (bus.frame_data !== exp_frame(8'h30)) begin bad++; $display("FAIL fly_f1 got=%h exp=%h", bus.frame_data, exp_frame(8'h30)); end
    send_frame(8'h40, 1'b0, pulses);
    total++; if (bus.frame_valid !== 1'b1 || bus.frame_data !== exp_frame(8'h40)) begin bad++; $display("FAIL fly_f2 got=%b/%h exp=1/%h", bus.frame_valid, bus.frame_data, exp_frame(8'h40)); end
    total++; if (bus.locked !== 1'b1) begin bad++; $display("FAIL fly_f2_locked got=%b exp=1", bus.locked); end
    send_frame(8'h50, 1'b0, pulses);
    total++; if (bus.frame_valid !== 1'b1 || bus.frame_data !== exp_frame(8'h50)) begin bad++; $display("FAIL fly_f3 got=%b/%h exp=1/%h", bus.frame_valid, bus.frame_data, exp_frame(8'h50)); end
    send(8'h60, 1'b0);
    total++; if (bus.locked !== 1'b0) begin bad++; $display("FAIL fly_unlock got=%b exp=0", bus.locked); end
    total++; if (bus.state !== HUNT) begin bad++; $display("FAIL fly_state got=%0d exp=HUNT", bus.state); end
    total++; if (bus.slot !== 3'd0) begin bad++; $display("FAIL fly_slot got=%0d exp=0", bus.slot); end
    total++; if (bus.frame_data !== exp_frame(8'h50) || bus.frame_valid !== 1'b0) begin bad++; $display("FAIL fly_hold got=%b/%h exp=0/%h", bus.frame_valid, bus.frame_data, exp_frame(8'h50)); end
  endtask

  task automatic test_hunt_drop;
    int pulses;
    pulses = 0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(8'(8'hE0 + 8'(i)), 1'b0);
      if (bus.frame_valid || bus.slot != 3'd0 || bus.locked) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL hunt_drop_activity got=%0d exp=0", pulses); end
    send_frame(8'h70, 1'b1, pulses);
    total++; if (bus.frame_valid !== 1'b1 || bus.frame_data !== exp_frame(8'h70)) begin bad++; $display("FAIL hunt_first_frame got=%b/%h exp=1/%h", bus.frame_valid, bus.frame_data, exp_frame(8'h70)); end
  endtask

  task automatic test_async_reset;
    send(8'h80, 1'b1);
    for (int i = 1; i < 6; i++) send(8'(8'h80 + 8'(i)), 1'b0);
    total++; if (bus.slot !== 3'd6) begin bad++; $display("FAIL ares_slot_before got=%0d exp=6", bus.slot); end
    #2;
    bus.din       = 8'h86;
    bus.din_valid = 1'b1;
    rst_n         = 1'b0;
    #1;
    total++; if (bus.frame_data !== 64'h0 || bus.locked !== 1'b0 || bus.slot !== 3'd0) begin bad++; $display("FAIL ares_immediate got=%h/%b/%0d exp=0/0/0", bus.frame_data, bus.locked, bus.slot); end
    repeat (2) begin @(posedge clk); #1; end
    total++; if (bus.frame_valid !== 1'b0 || bus.frame_data !== 64'h0) begin bad++; $display("FAIL ares_no_commit got=%b/%h exp=0/0", bus.frame_valid, bus.frame_data); end
    bus.din_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h86, 1'b0);
    send(8'h87, 1'b0);
    total++; if (bus.state !== HUNT || bus.slot !== 3'd0 || bus.frame_valid !== 1'b0) begin bad++; $display("FAIL ares_hunt got=%0d/%0d/%b exp=HUNT/0/0", bus.state, bus.slot, bus.frame_valid); end
  endtask

  initial begin
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    test_reset();
    test_aligned();
    test_gapped();
    test_misalign();
    test_flywheel();
    test_hunt_drop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
